// File: rtl/api_ext_master.sv
// Local-request to external I/O port bridge: issues one READ/WRITE command,
// tracks the responder's BUSY/READY handshake and aborts any phase that stalls too long.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; command is IDLE
// ISSUE   | command driven, waiting for responder to report BUSY
// WAIT    | responder busy, waiting for READY/ERROR (reserved = ERROR)
// RELEASE | command dropped, waiting for responder to return to READY
// ABORT   | timeout response on the outputs, back to IDLE next cycle
module api_ext_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_read_data,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [1:0]  command,
    input  logic [1:0]  status,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    localparam logic [1:0] CMD_IDLE  = 2'h0;
    localparam logic [1:0] CMD_READ  = 2'h1;
    localparam logic [1:0] CMD_WRITE = 2'h3;
    localparam logic [1:0] ST_BUSY   = 2'h0;
    localparam logic [1:0] ST_READY  = 2'h1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_ABORT
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic [31:0] cap_data;
    logic        cap_error;
    logic        exit_now;
    logic        timer_expired;

    assign req_ready     = (state == S_IDLE);
    assign timer_expired = (timer >= (TIMEOUT_CYCLES - 16'd1));

    always_comb begin
        exit_now = 1'b0;
        case (state)
            S_ISSUE:   exit_now = (status == ST_BUSY);
            S_WAIT:    exit_now = (status != ST_BUSY);
            S_RELEASE: exit_now = (status == ST_READY);
            default:   exit_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= 16'd0;
            command       <= CMD_IDLE;
            address       <= 32'h0;
            write_data    <= 32'h0;
            cap_data      <= 32'h0;
            cap_error     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_read_data <= 32'h0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        address <= req_address;
                        if (req_we) begin
                            write_data <= req_write_data;
                        end
                        command <= req_we ? CMD_WRITE : CMD_READ;
                        timer   <= 16'd0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT, S_RELEASE: begin
                    // A phase exit takes priority over an expiring timer.
                    if (exit_now) begin
                        timer <= 16'd0;
                        if (state == S_ISSUE) begin
                            state <= S_WAIT;
                        end else if (state == S_WAIT) begin
                            cap_data  <= read_data;
                            cap_error <= (status != ST_READY);
                            command   <= CMD_IDLE;
                            state     <= S_RELEASE;
                        end else begin
                            rsp_valid     <= 1'b1;
                            rsp_read_data <= cap_data;
                            rsp_error     <= cap_error;
                            rsp_timeout   <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end else if (timer_expired) begin
                        command       <= CMD_IDLE;
                        rsp_valid     <= 1'b1;
                        rsp_error     <= 1'b1;
                        rsp_timeout   <= 1'b1;
                        rsp_read_data <= 32'h0;
                        state         <= S_ABORT;
                    end else if (timer != 16'hffff) begin
                        timer <= timer + 16'd1;
                    end
                end
                S_ABORT: begin
                    timer <= 16'd0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_api_ext_master.sv
// Bench for api_ext_master: clocked responder device plus a transaction-level
// predictor of response data, error/timeout flags and completion latency.
module tb_api_ext_master;

    localparam logic [15:0] TO   = 16'd8;
    localparam int          TO_I = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        rsp_valid;
    logic [31:0] rsp_read_data;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [1:0]  command;
    logic [1:0]  status;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    api_ext_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_address(req_address), .req_write_data(req_write_data),
        .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .command(command), .status(status), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Responder device: BUSY for cfg_busy cycles after a new command, then a result.
    logic [31:0] dev_mem [256];
    int          cfg_busy  = 1;
    bit          resp_stuck = 1'b0;
    int          busy_left = 0;
    logic [1:0]  prev_cmd  = 2'h0;

    initial begin
        status    = 2'h1;
        read_data = 32'h0;
    end

    always @(negedge clk) begin
        if (resp_stuck) begin
            status = 2'h1;
        end else if (command == 2'h0) begin
            status    = 2'h1;
            busy_left = 0;
        end else if (prev_cmd == 2'h0) begin
            busy_left = cfg_busy;
            status    = 2'h0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                if (address[31:24] == 8'h55) begin
                    status = 2'h3; read_data = 32'hdeaddead;
                end else if (address[31:24] == 8'h56) begin
                    status = 2'h2; read_data = 32'hbad0bad0;
                end else if (command == 2'h3) begin
                    dev_mem[address[7:0]] = write_data;
                    status = 2'h1; read_data = 32'h0;
                end else begin
                    status = 2'h1;
                    if (address == 32'h2)       read_data = 32'h302e3230;
                    else if (address == 32'h12) read_data = dev_mem[8'h10] + dev_mem[8'h11];
                    else                        read_data = dev_mem[address[7:0]];
                end
            end
        end
        prev_cmd = command;
    end

    // Reference model: what a completed transaction should return.
    logic [31:0] exp_mem [256];
    logic [31:0] exp_wdata;

    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input bit commit, output logic [31:0] d, output logic e);
        e = 1'b0;
        d = 32'h0;
        if (addr[31:24] == 8'h55) begin
            e = 1'b1; d = 32'hdeaddead;
        end else if (addr[31:24] == 8'h56) begin
            e = 1'b1; d = 32'hbad0bad0;
        end else if (we) begin
            if (commit) exp_mem[addr[7:0]] = wd;
        end else if (addr == 32'h2) begin
            d = 32'h302e3230;
        end else if (addr == 32'h12) begin
            d = exp_mem[8'h10] + exp_mem[8'h11];
        end else begin
            d = exp_mem[addr[7:0]];
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, req_ready, 1'b1);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int busy, input string tag);
        logic [31:0] e_data;
        logic        e_err;
        logic        e_to;
        int          e_lat;
        int          lat;
        bit          seen;
        bit          stable;
        if (resp_stuck) begin
            e_to = 1'b1; e_err = 1'b1; e_data = 32'h0; e_lat = TO_I;
        end else if (busy - 1 >= TO_I) begin
            e_to = 1'b1; e_err = 1'b1; e_data = 32'h0; e_lat = TO_I + 1;
        end else begin
            e_to = 1'b0; e_lat = busy + 2;
            predict(we, addr, wd, 1'b1, e_data, e_err);
        end
        if (we) exp_wdata = wd;
        cfg_busy = busy;
        wait_ready(tag);
        req_valid = 1'b1; req_we = we; req_address = addr; req_write_data = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_address = $urandom; req_write_data = $urandom;
        check({tag, "/cmd"}, command, we ? 2'h3 : 2'h1);
        check({tag, "/addr"}, address, addr);
        check({tag, "/wdata"}, write_data, exp_wdata);
        stable = 1'b1;
        seen   = 1'b0;
        lat    = 0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1'b1;
            if (address !== addr || write_data !== exp_wdata) stable = 1'b0;
        end
        check({tag, "/seen"}, seen, 1'b1);
        check({tag, "/latency"}, lat, e_lat);
        check({tag, "/rdata"}, rsp_read_data, e_data);
        check({tag, "/err"}, rsp_error, e_err);
        check({tag, "/tmo"}, rsp_timeout, e_to);
        check({tag, "/cmd_idle"}, command, 2'h0);
        check({tag, "/stable"}, stable, 1'b1);
        @(negedge clk);
        check({tag, "/pulse"}, rsp_valid, 1'b0);
    endtask

    initial begin : main
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e_data;
        logic        e_err;
        logic        we;
        bit          ok;
        int          n;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        exp_wdata = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_address = 32'h0; req_write_data = 32'h0;
        #12;
        check("rst/ready", req_ready, 1'b1);
        check("rst/cmd", command, 2'h0);
        check("rst/addr", address, 32'h0);
        check("rst/wdata", write_data, 32'h0);
        check("rst/rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b000);
        check("rst/rdata", rsp_read_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst/ready", req_ready, 1'b1);

        do_txn(1'b0, 32'h00000002, 32'h0, 3, "rd_version");
        check("rd_version/const", rsp_read_data, 32'h302e3230);
        do_txn(1'b1, 32'h00000010, 32'h5, 3, "wr10");
        do_txn(1'b1, 32'h00000011, 32'h7, 3, "wr11");
        do_txn(1'b0, 32'h00000012, 32'h0, 3, "rd_sum");
        check("rd_sum/const", rsp_read_data, 32'h0000000c);
        check("rd_sum/wdata_kept", write_data, 32'h7);
        do_txn(1'b0, 32'h55000000, 32'h0, 2, "rd_unmapped");
        check("rd_unmapped/const", rsp_read_data, 32'hdeaddead);
        do_txn(1'b0, 32'h56000004, 32'h0, 1, "rd_reserved");

        resp_stuck = 1'b1;
        do_txn(1'b0, 32'h00000020, 32'h0, 1, "stuck_ready");
        resp_stuck = 1'b0;
        do_txn(1'b1, 32'h00000021, 32'h1234, 8, "exit_at_limit");
        do_txn(1'b1, 32'h00000022, 32'h9999, 9, "busy_timeout");
        do_txn(1'b0, 32'h00000022, 32'h0, 1, "rd_after_tmo");

        // Reset while the responder is still busy.
        cfg_busy = 6;
        wait_ready("rst_wait");
        req_valid = 1'b1; req_we = 1'b0; req_address = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_wait/cmd", command, 2'h0);
        check("rst_wait/rsp", rsp_valid, 1'b0);
        check("rst_wait/ready", req_ready, 1'b1);
        exp_wdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        check("rst_wait/no_rsp", ok, 1'b1);
        do_txn(1'b0, 32'h00000011, 32'h0, 2, "rd_after_rst");

        // Back-to-back with req_valid held: the second request must wait.
        cfg_busy = 2;
        wait_ready("b2b");
        exp_mem[8'h23] = 32'hcafe0001;
        exp_wdata = 32'hcafe0001;
        req_valid = 1'b1; req_we = 1'b1; req_address = 32'h23; req_write_data = 32'hcafe0001;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_address = 32'h10; req_write_data = 32'h0;
        ok = 1'b1;
        n  = 0;
        while (!rsp_valid && n < 40) begin
            if (address !== 32'h23 || (command !== 2'h3 && command !== 2'h0)) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("b2b/first_rsp", rsp_valid, 1'b1);
        check("b2b/not_queued", ok, 1'b1);
        check("b2b/no_overlap", command, 2'h0);
        @(negedge clk);
        check("b2b/second_cmd", command, 2'h1);
        check("b2b/second_addr", address, 32'h10);
        req_valid = 1'b0;
        predict(1'b0, 32'h10, 32'h0, 1'b1, e_data, e_err);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b/second_rsp", rsp_valid, 1'b1);
        check("b2b/second_data", rsp_read_data, e_data);
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom);
            d  = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h10;
                1: a = 32'h11;
                2: a = 32'h12;
                3: a = 32'h2;
                4: a = 32'h20 + 32'($urandom_range(0, 3));
                5: a = {8'h55, 24'($urandom)};
                6: a = {8'h56, 24'($urandom)};
                default: a = 32'h30;
            endcase
            do_txn(we, a, d, int'($urandom_range(1, 11)), $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
